// File: rtl/sobel_strip_engine.sv
// Sobel gradient engine: 3-row sliding window walked by a 3-stage column pipeline.
// Define SOBEL_LOW_THRESH_EN to add low_thresh magnitude/angle suppression.
module sobel_strip_engine #(
    parameter int STRIP_W   = 14,
    parameter int PIX_BITS  = 8,
    parameter int GRAD_BITS = PIX_BITS + 3,
    parameter int MAG_BITS  = PIX_BITS
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            row_valid,
    input  logic                            row_first,
    input  logic [(STRIP_W+2)*PIX_BITS-1:0] row_in,
`ifdef SOBEL_LOW_THRESH_EN
    input  logic [MAG_BITS-1:0]             low_thresh,
`endif
    output logic                            row_ready,
    output logic [STRIP_W*GRAD_BITS-1:0]    grad_x,
    output logic [STRIP_W*GRAD_BITS-1:0]    grad_y,
    output logic [STRIP_W*MAG_BITS-1:0]     grad_mag,
    output logic [STRIP_W*2-1:0]            grad_angle,
    output logic                            out_valid,
    output logic                            busy
);
    localparam int NPIX = STRIP_W + 2;
    localparam int IW   = $clog2(STRIP_W + 4);
    localparam int WI   = $clog2(NPIX);
    localparam int OI   = $clog2(STRIP_W);
    localparam int AW   = GRAD_BITS + 3;
    localparam int SH   = GRAD_BITS - MAG_BITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          ready_q;
    logic          valid_q;
    logic          busy_q;
    logic          accept;

    logic [PIX_BITS-1:0] win_q [3][NPIX];

    logic signed [GRAD_BITS-1:0] hd_q [3];
    logic signed [GRAD_BITS-1:0] vd_q [3];
    logic signed [GRAD_BITS-1:0] hd_d [3];
    logic signed [GRAD_BITS-1:0] vd_d [3];
    logic signed [GRAD_BITS-1:0] gx_q, gy_q;
    logic signed [GRAD_BITS-1:0] gx_d, gy_d;

    logic signed [GRAD_BITS-1:0] gx_o_q [STRIP_W];
    logic signed [GRAD_BITS-1:0] gy_o_q [STRIP_W];
    logic [MAG_BITS-1:0]         mag_o_q [STRIP_W];
    logic [1:0]                  ang_o_q [STRIP_W];

    logic [IW-1:0]        cs;
    logic [WI-1:0]        i0, i1, i2;
    logic [OI-1:0]        o2, o3;
    logic [GRAD_BITS-1:0] ax, ay;
    logic [AW-1:0]        ax_w, ay_w;
    logic [MAG_BITS-1:0]  mag_c, mag_f;
    logic [1:0]           ang_c, ang_f;

`ifdef SOBEL_LOW_THRESH_EN
    logic [MAG_BITS-1:0] thresh_q;
`endif

    assign accept    = row_valid && ready_q;
    assign row_ready = ready_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

    function automatic logic signed [GRAD_BITS-1:0] sx(
        input logic [PIX_BITS-1:0] p
    );
        return $signed({{(GRAD_BITS-PIX_BITS){1'b0}}, p});
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (idx_q == IW'(STRIP_W + 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A first row fills the whole window so the top border replicates it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < 3; r++)
                for (int i = 0; i < NPIX; i++)
                    win_q[r][i] <= '0;
`ifdef SOBEL_LOW_THRESH_EN
            thresh_q <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < NPIX; i++) begin
                win_q[0][i] <= row_in[i*PIX_BITS +: PIX_BITS];
                win_q[1][i] <= row_first ? row_in[i*PIX_BITS +: PIX_BITS]
                                         : win_q[0][i];
                win_q[2][i] <= row_first ? row_in[i*PIX_BITS +: PIX_BITS]
                                         : win_q[1][i];
            end
`ifdef SOBEL_LOW_THRESH_EN
            thresh_q <= low_thresh;
`endif
        end
    end

    always_comb begin
        cs = (idx_q < IW'(STRIP_W)) ? idx_q : '0;
        i0 = WI'(cs);
        i1 = WI'(cs + IW'(1));
        i2 = WI'(cs + IW'(2));
        o2 = OI'(idx_q - IW'(1));
        o3 = OI'(idx_q - IW'(2));
        for (int r = 0; r < 3; r++)
            hd_d[r] = sx(win_q[r][i2]) - sx(win_q[r][i0]);
        vd_d[0] = sx(win_q[0][i0]) - sx(win_q[2][i0]);
        vd_d[1] = sx(win_q[0][i1]) - sx(win_q[2][i1]);
        vd_d[2] = sx(win_q[0][i2]) - sx(win_q[2][i2]);
        gx_d = hd_q[2] + (hd_q[1] <<< 1) + hd_q[0];
        gy_d = vd_q[0] + (vd_q[1] <<< 1) + vd_q[2];
    end

    always_comb begin
        ax    = gx_q[GRAD_BITS-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay    = gy_q[GRAD_BITS-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        ax_w  = AW'(ax);
        ay_w  = AW'(ay);
        mag_c = MAG_BITS'((ax_w + ay_w) >> SH);
        // Ratio tests approximate tan(22 deg) ~ 2/5 without a divider
        if (((ay_w << 2) + ay_w) <= (ax_w << 1))
            ang_c = 2'd0;
        else if (((ax_w << 2) + ax_w) <= (ay_w << 1))
            ang_c = 2'd2;
        else if (gx_q[GRAD_BITS-1] == gy_q[GRAD_BITS-1])
            ang_c = 2'd1;
        else
            ang_c = 2'd3;
        mag_f = mag_c;
        ang_f = ang_c;
`ifdef SOBEL_LOW_THRESH_EN
        if (mag_c < thresh_q) begin
            mag_f = '0;
            ang_f = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 3; k++) begin
                hd_q[k] <= '0;
                vd_q[k] <= '0;
            end
            gx_q <= '0;
            gy_q <= '0;
            for (int c = 0; c < STRIP_W; c++) begin
                gx_o_q[c]  <= '0;
                gy_o_q[c]  <= '0;
                mag_o_q[c] <= '0;
                ang_o_q[c] <= '0;
            end
        end else if (state_q == RUN) begin
            if (idx_q < IW'(STRIP_W)) begin
                hd_q <= hd_d;
                vd_q <= vd_d;
            end
            if (idx_q >= IW'(1) && idx_q <= IW'(STRIP_W)) begin
                gx_q       <= gx_d;
                gy_q       <= gy_d;
                gx_o_q[o2] <= gx_d;
                gy_o_q[o2] <= gy_d;
            end
            if (idx_q >= IW'(2)) begin
                mag_o_q[o3] <= mag_f;
                ang_o_q[o3] <= ang_f;
            end
        end
    end

    for (genvar c = 0; c < STRIP_W; c++) begin : g_pack
        assign grad_x[c*GRAD_BITS +: GRAD_BITS] = gx_o_q[c];
        assign grad_y[c*GRAD_BITS +: GRAD_BITS] = gy_o_q[c];
        assign grad_mag[c*MAG_BITS +: MAG_BITS] = mag_o_q[c];
        assign grad_angle[c*2 +: 2]             = ang_o_q[c];
    end

endmodule

// File: doc/sobel_strip_engine.md
# sobel_strip_engine

Parametrised Sobel gradient engine for the edge-detector datapath. It maintains a three-row sliding window of a strip of `STRIP_W+2` pixels and walks a three-stage column pipeline across the strip. For every column it produces the signed gradients, magnitude and quantised direction. It succeeds the fixed 14-pixel gradient stage with configurable strip width and pixel depth, a valid/ready row handshake, first-row replication driven by an explicit flag, and a done strobe with stable results.

## Interface
Parameters:
- `STRIP_W`, 14: output pixels per strip; input strip is `STRIP_W+2` pixels. Must be ≥ 2.
- `PIX_BITS`, 8: unsigned input pixel width.
- `GRAD_BITS`, `PIX_BITS+3`: signed gradient width; holds ±4·(2^PIX_BITS−1).
- `MAG_BITS`, `PIX_BITS`: magnitude width.

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `row_valid`  in  1  `row_in` holds a new strip row.
- `row_first`  in  1  qualifies `row_valid`: first row of frame, replicate into the window.
- `row_in`  in  `(STRIP_W+2)×PIX_BITS`  strip row, element 0 leftmost.
- `row_ready`  out  1  engine accepts a row this cycle.
- `grad_x`, `grad_y`  out  `STRIP_W×GRAD_BITS`  signed gradients per column.
- `grad_mag`  out  `STRIP_W×MAG_BITS`  magnitude per column.
- `grad_angle`  out  `STRIP_W×2`  direction code per column.
- `out_valid`  out  1  one-cycle pulse: all output arrays are consistent for the last accepted row.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Window: `win[0]` is the newest row (bottom), `win[2]` the oldest (top).
- Accept = `row_valid && row_ready`. On accept: `win[2]<=win[1]`, `win[1]<=win[0]`, `win[0]<=row_in`. If `row_first` is set, all three rows load `row_in` instead.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on accept.
  - RUN → DONE when `idx==STRIP_W+1`.
  - DONE → RUN on accept, otherwise DONE → IDLE.
  - `row_ready` = state ∈ {IDLE, DONE}. `row_valid` is ignored in RUN.
- Column index `idx` counts 0..`STRIP_W+1` in RUN and clears on RUN entry.
- Pipeline for column c:
  - Stage 1, when `idx==c` and c<`STRIP_W`: register three per-row horizontal differences `row[c+2]−row[c]` and three per-column vertical differences `win[0][c+k]−win[2][c+k]`, for k=0..2.
  - Stage 2, when `idx==c+1`: apply weights 1,2,1 (rows 2,1,0 for gx; k=0,1,2 for gy). Write `grad_x[c]` and `grad_y[c]`.
  - Stage 3, when `idx==c+2`: compute `ax=|gx|`, `ay=|gy|`. Write `grad_mag[c]=(ax+ay)>>(GRAD_BITS−MAG_BITS)`. This is exact, with no saturation.
- Angle codes:
  - 0 (horizontal gradient) if 5·ay ≤ 2·ax, which includes gx=gy=0.
  - 2 (vertical) else if 5·ax ≤ 2·ay.
  - 1 else if gx and gy have the same sign.
  - 3 otherwise.
- All arithmetic is signed at `GRAD_BITS`, with no overflow by construction.

## Timing
- Reset values:
  - state IDLE; `idx` 0; window 0.
  - all output arrays 0.
  - `row_ready` 1; `out_valid` 0; `busy` 0.
- Accept at cycle T: RUN runs T+1..T+`STRIP_W`+2, DONE at T+`STRIP_W`+3 with `out_valid`=1.
- Back-to-back accept in DONE gives a period of `STRIP_W`+3 cycles per row.
- Output arrays change only during RUN. They hold between DONE and the next RUN's first write, which is stage 2 of column 0 at RUN `idx` 1.
- Reset asserted mid-RUN aborts immediately: all state returns to reset values and no `out_valid` is issued.
- `row_first` without `row_valid`, or outside an accept, has no effect.

## Configuration
- `SOBEL_LOW_THRESH_EN` defined:
  - Adds input `low_thresh` (`MAG_BITS`), sampled on accept.
  - Stage 3 forces `grad_mag[c]` and `grad_angle[c]` to 0 when the computed magnitude < `low_thresh`.
  - `grad_x` and `grad_y` are unaffected.
- Undefined: the port is absent and magnitudes are never suppressed.

## Test plan
- Reset → `row_ready`=1, `out_valid`=0, all outputs 0. Also assert `n_rst` mid-RUN → same reset values, no `out_valid`.
- `STRIP_W`=14, accept a constant row of 100 with `row_first` → `out_valid` exactly 17 cycles after accept; all gx=gy=0, mag 0, angle 0.
- Row 0,0,…,255,… step at column 8 with `row_first` → columns 6,7: gx=1020, gy=0, mag 127, angle 0; other columns 0.
- Three rows of 0, 0, 255 (last accepted 255) → gy=1020, gx=0, angle 2, mag 127.
- Diagonal ramp `p[r][c]=10·(c+r')` → gx=80, gy=80 (sign per row order), angle 1 or 3, mag 20. Back-to-back accept in DONE → `out_valid` period 17, `row_valid` in RUN ignored.
- With `SOBEL_LOW_THRESH_EN`, `low_thresh`=30, mag-20 case → mag 0, angle 0, gx=80 unchanged.
